// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

   localparam int N      = 32;
   localparam int STAGES = 5;
   localparam int SHW    = $clog2(N);
   localparam int STW    = $clog2(STAGES);

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } seq_state_t;

   // SRL (01) and SRA (11) shift right; SLL and the reserved 10 shift left.
   function automatic logic op_is_right(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/shift_stage.sv
// Single power-of-two shift stage: shifts acc by 2^stage left or right, filling with fill.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module shift_stage
   import shift_pkg::*;
(
   input  logic [N-1:0]   acc,
   input  logic [STW-1:0] stage,
   input  logic           dir,
   input  logic           fill,
   output logic [N-1:0]   result
);

   logic [N-1:0] fillv;
   logic [N-1:0] cand [STAGES];

   assign fillv = {N{fill}};

   // One fixed-distance candidate per stage; dir=1 shifts right.
   for (genvar k = 0; k < STAGES; k++) begin : g_cand
      localparam int A = 1 << k;
      assign cand[k] = dir ? {fillv[A-1:0], acc[N-1:A]}
                           : {acc[N-1-A:0], fillv[A-1:0]};
   end

   // Pick the candidate matching the current stage index.
   always_comb begin
      result = acc;
      for (int k = 0; k < STAGES; k++) begin
         if (stage == k[STW-1:0]) begin
            result = cand[k];
         end
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit reusing one power-of-two stage over five cycles.
// Latency: result valid exactly 5 edges after the accept edge, regardless of shamt.
// Backpressure: result held in DONE until out_ready; new request accepted only in IDLE or on the draining edge.
module shift_sequencer
   import shift_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_data,
   input  logic [SHW-1:0] in_shamt,
   input  logic [1:0]     in_op,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data,
   output logic           busy
);

   seq_state_t     state_q;
   seq_state_t     state_d;
   logic [N-1:0]   acc_q;
   logic [SHW-1:0] shamt_q;
   logic [1:0]     op_q;
   logic           fill_q;
   logic [STW-1:0] stage_q;
   logic [N-1:0]   stage_out;
   logic           accept;
   logic           last_stage;

   shift_stage u_stage (
      .acc    (acc_q),
      .stage  (stage_q),
      .dir    (op_is_right(op_q)),
      .fill   (fill_q),
      .result (stage_out)
   );

   assign last_stage = (stage_q == STW'(STAGES - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake decode; in_ready never depends on in_valid.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (last_stage) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               accept  = in_valid;
               state_d = in_valid ? S_SHIFT : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Operand capture on accept, then one conditional power-of-two shift per SHIFT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         shamt_q <= '0;
         op_q    <= '0;
         fill_q  <= 1'b0;
         stage_q <= '0;
      end else if (accept) begin
         acc_q   <= in_data;
         shamt_q <= in_shamt;
         op_q    <= in_op;
         fill_q  <= (in_op == SHIFT_SRA) ? in_data[N-1] : 1'b0;
         stage_q <= '0;
      end else if (state_q == S_SHIFT) begin
         if (shamt_q[stage_q]) begin
            acc_q <= stage_out;
         end
         stage_q <= stage_q + 1'b1;
      end
   end

   assign out_data = acc_q;

endmodule
